// File: rtl/sig_collector.sv
// sig_collector: gathers discrete asynchronous signals back into a bus word.
// Each input is synchronised, per-bit sticky change flags are latched, and a
// maskable interrupt is raised. Registers are reached over Wishbone-classic.
module sig_collector #(
  parameter int SH = 7,
  parameter int SL = 0,
  parameter int BW = 32
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic [SH:SL]  i_sig,
  input  logic          i_wb_cyc,
  input  logic          i_wb_stb,
  input  logic          i_wb_we,
  input  logic [1:0]    i_wb_addr,
  input  logic [BW-1:0] i_wb_data,
  output logic [BW-1:0] o_wb_data,
  output logic          o_wb_ack,
  output logic          o_irq
);

  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t       state, state_nx;
  logic [1:0]   fill_cnt, fill_cnt_nx;

  logic [SH:SL] sync1, sync2, prev;
  logic [SH:SL] flags, mask;
  logic [SH:SL] set_bits, clr_bits;
  logic         req, wr_flags, wr_mask;
  logic [BW-1:0] rd_word;

  // Only bits [SH:SL] of the write data are meaningful; the rest is dropped.
  logic unused_wdata;
  assign unused_wdata = ^i_wb_data;

  // Two-flop synchroniser, plus a copy of the previous synchronised value for edge detection.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      sync1 <= '0;
      sync2 <= '0;
      prev  <= '0;
    end else begin
      sync1 <= i_sig;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  // State register for the start-up fill sequencer.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state    <= FILL;
      fill_cnt <= 2'd0;
    end else begin
      state    <= state_nx;
      fill_cnt <= fill_cnt_nx;
    end
  end

  // Stay in FILL until both sync stages and prev hold real post-reset samples,
  // so inputs already high at reset do not look like edges.
  always_comb begin
    state_nx    = state;
    fill_cnt_nx = fill_cnt;
    case (state)
      FILL: begin
        if (fill_cnt == 2'd2) begin
          state_nx = RUN;
        end else begin
          fill_cnt_nx = fill_cnt + 2'd1;
        end
      end
      RUN: begin
        state_nx = RUN;
      end
      default: begin
        state_nx = FILL;
      end
    endcase
  end

  // Decode a bus request and the write strobes / set-clear vectors it produces.
  always_comb begin
    req      = i_wb_cyc & i_wb_stb & ~o_wb_ack;
    wr_flags = req & i_wb_we & (i_wb_addr == 2'd1);
    wr_mask  = req & i_wb_we & (i_wb_addr == 2'd2);
    clr_bits = wr_flags ? i_wb_data[SH:SL] : '0;
    set_bits = (state == RUN) ? (sync2 ^ prev) : '0;
  end

  // Sticky change flags with W1C; a new edge in the clearing cycle still sets the flag.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      flags <= '0;
    end else begin
      flags <= (flags & ~clr_bits) | set_bits;
    end
  end

  // Interrupt mask register.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      mask <= '0;
    end else if (wr_mask) begin
      mask <= i_wb_data[SH:SL];
    end
  end

  // Read multiplexer; bits outside [SH:SL] and the unused address always read 0.
  always_comb begin
    rd_word = '0;
    case (i_wb_addr)
      2'd0:    rd_word[SH:SL] = sync2;
      2'd1:    rd_word[SH:SL] = flags;
      2'd2:    rd_word[SH:SL] = mask;
      default: rd_word = '0;
    endcase
  end

  // Registered acknowledge, read data and interrupt.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_wb_ack  <= 1'b0;
      o_wb_data <= '0;
      o_irq     <= 1'b0;
    end else begin
      o_wb_ack  <= req;
      o_wb_data <= (req && !i_wb_we) ? rd_word : '0;
      o_irq     <= |(flags & mask);
    end
  end

endmodule
